// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// functs, ALU op classes and ALU control codes, reused by datapath and bench.
package multicycle_controller_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU control decode: maps the FSM's aluop class plus the R-type funct field
// onto the 3-bit ALU operation select; purely combinational.
module aludec
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle MIPS datapath (lw/sw/R-type/beq/addi/j);
// one state per clock, instructions take 2-5 clocks, no handshake on inputs.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       alusrca,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_RTYPEEX;
          OP_BEQ:       state_nxt = S_BEQEX;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JEX;
          default:      state_nxt = S_FETCH;
        endcase
      end
      // op is still held by the instruction register, so it picks lw vs sw here
      S_MEMADR:  state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_nxt = S_MEMWB;
      S_RTYPEEX: state_nxt = S_RTYPEWB;
      S_ADDIEX:  state_nxt = S_ADDIWB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    iord     = 1'b0;
    alusrca  = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen = pcwrite | (branch & zero);

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule
